// File: rtl/expr_resp_pkg.sv
// Shared types and signature arithmetic for the expression response compactor.
// The fold/step functions are also used by the upstream golden-model harness.
package expr_resp_pkg;

    localparam int          Y_W_DEF = 90;
    localparam logic [31:0] SEED    = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Collapse the 90-bit result vector onto 32 bits; the top slice is zero-extended.
    function automatic logic [31:0] fold(input logic [Y_W_DEF-1:0] y);
        return y[31:0] ^ y[63:32] ^ {6'b000000, y[89:64]};
    endfunction

    // One MISR clock: shift with feedback through POLY, then inject the folded vector.
    function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] t;
        t = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0000_0000);
        return t ^ f;
    endfunction

endpackage

// File: rtl/expr_misr_step.sv
// Combinational MISR update: fold the result vector, then advance the signature one step.
module expr_misr_step
    import expr_resp_pkg::*;
#(
    parameter int Y_W = Y_W_DEF
) (
    input  logic [31:0]    sig_in,
    input  logic [Y_W-1:0] y,
    output logic [31:0]    sig_out
);

    assign sig_out = step(sig_in, fold(y));

endmodule

// File: rtl/expr_resp_misr.sv
// Response compactor: folds accepted result vectors into a MISR signature and,
// after the programmed count, compares it against the expected signature.
module expr_resp_misr
    import expr_resp_pkg::*;
#(
    parameter int Y_W   = Y_W_DEF,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] vec_cnt
);

    state_t           state_r, state_nxt_s;
    logic [SIG_W-1:0] sig_r, sig_nxt_s, step_sig_s;
    logic [CNT_W-1:0] vec_cnt_r, vec_cnt_nxt_s;
    logic [CNT_W-1:0] num_vec_r, num_vec_nxt_s;
    logic [SIG_W-1:0] exp_sig_r, exp_sig_nxt_s;
    logic             pass_r, pass_nxt_s;
    logic             in_ready_s;

    expr_misr_step #(.Y_W(Y_W)) u_step (
        .sig_in  (sig_r),
        .y       (in_y),
        .sig_out (step_sig_s)
    );

    // Next-state and datapath update; in_ready depends on state alone.
    always_comb begin
        state_nxt_s   = state_r;
        sig_nxt_s     = sig_r;
        vec_cnt_nxt_s = vec_cnt_r;
        num_vec_nxt_s = num_vec_r;
        exp_sig_nxt_s = exp_sig_r;
        pass_nxt_s    = pass_r;
        in_ready_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    num_vec_nxt_s = num_vec;
                    exp_sig_nxt_s = exp_sig;
                    sig_nxt_s     = SEED;
                    vec_cnt_nxt_s = '0;
                    pass_nxt_s    = 1'b0;
                    state_nxt_s   = (num_vec != '0) ? RUN : CHECK;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            RUN: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    sig_nxt_s     = step_sig_s;
                    vec_cnt_nxt_s = vec_cnt_r + CNT_W'(1);
                    if ((vec_cnt_r + CNT_W'(1)) == num_vec_r) begin
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            CHECK: begin
                pass_nxt_s  = (sig_r == exp_sig_r);
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Signature, counter, latched run parameters and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r     <= SEED;
            vec_cnt_r <= '0;
            num_vec_r <= '0;
            exp_sig_r <= '0;
            pass_r    <= 1'b0;
        end else begin
            sig_r     <= sig_nxt_s;
            vec_cnt_r <= vec_cnt_nxt_s;
            num_vec_r <= num_vec_nxt_s;
            exp_sig_r <= exp_sig_nxt_s;
            pass_r    <= pass_nxt_s;
        end
    end

    assign in_ready = in_ready_s;
    assign busy     = (state_r == RUN) || (state_r == CHECK);
    assign done     = (state_r == DONE);
    assign pass     = pass_r;
    assign sig      = sig_r;
    assign vec_cnt  = vec_cnt_r;

endmodule
